// File: rtl/softplus_arb_pkg.sv
// softplus_arb_pkg: shared types and constants for the softplus arbiter.
//   Q_W      - Q8.8 operand/result width
//   tag_t    - requester tag (TAG_A = 0, TAG_B = 1)
//   stage_t  - pipeline payload (operand or result plus tag)
//   OFF_POS / OFF_NEG - softplus offset tables indexed by x[10:8]
package softplus_arb_pkg;

   localparam int unsigned Q_W   = 16;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned IDX_N = 8;

   typedef enum logic {
      TAG_A = 1'b0,
      TAG_B = 1'b1
   } tag_t;

   typedef struct packed {
      logic [Q_W-1:0] data;
      tag_t           tag;
   } stage_t;

   // Offsets for non-negative operands; index is the integer field x[10:8].
   localparam logic [Q_W-1:0] OFF_POS [IDX_N] = '{
      16'h004D, 16'h0037, 16'h001F, 16'h000F,
      16'h0007, 16'h0000, 16'h0000, 16'h0000
   };

   // Offsets for negative operands; -1 (x[10:8] = 111) is closest to zero.
   localparam logic [Q_W-1:0] OFF_NEG [IDX_N] = '{
      16'h0002, 16'h0002, 16'h0002, 16'h0007,
      16'h000F, 16'h001F, 16'h0037, 16'h004D
   };

endpackage

// File: rtl/softplus_arb_lut.sv
// sp_offset_lut: combinational softplus offset lookup.
//   operand - Q8.8 operand (sign and integer field x[10:8] are used)
//   offset  - Q8.8 offset to add to relu(operand)
module sp_offset_lut
   import softplus_arb_pkg::*;
(
   input  logic [Q_W-1:0] operand,
   output logic [Q_W-1:0] offset
);

   logic [IDX_W-1:0] idx;

   assign idx = operand[10:8];

   // Sign selects the table, integer field selects the entry.
   always_comb begin
      offset = '0;
      if (operand[Q_W-1]) offset = OFF_NEG[idx];
      else                offset = OFF_POS[idx];
   end

endmodule

// File: rtl/softplus_arb.sv
// softplus_arb: two-requester round-robin arbiter feeding a two-stage
// softplus approximation pipeline (relu(x) + table offset), Q8.8.
//   clk, rst                     - clock, asynchronous active-high reset
//   a_valid/a_data/a_ready       - requester A (tag 0)
//   b_valid/b_data/b_ready       - requester B (tag 1)
//   out_valid/out_data/out_tag   - result stream, held until out_ready
//   busy                         - high while S1 or S2 holds data
module softplus_arb
   import softplus_arb_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           a_valid,
   input  logic [Q_W-1:0] a_data,
   output logic           a_ready,
   input  logic           b_valid,
   input  logic [Q_W-1:0] b_data,
   output logic           b_ready,
   output logic           out_valid,
   output logic [Q_W-1:0] out_data,
   output logic           out_tag,
   input  logic           out_ready,
   output logic           busy
);

   stage_t         s1_q, s1_n;
   logic           s1_valid, s1_valid_n;
   logic           out_valid_n, out_tag_n, busy_n;
   logic [Q_W-1:0] out_data_n;
   tag_t           last_grant, last_grant_n;

   logic           s2_load, s1_can_load;
   logic           grant_a, grant_b;
   stage_t         in_stage;
   logic [Q_W-1:0] offset, relu, sum;

   // S2 (the output register) frees up when empty or draining this cycle;
   // S1 can load when empty or when its content moves into S2.
   assign s2_load     = ~out_valid | out_ready;
   assign s1_can_load = ~s1_valid | s2_load;

   // Round-robin grant; A wins a tie unless A was granted last.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst && s1_can_load) begin
         if (a_valid && (!b_valid || last_grant == TAG_B)) grant_a = 1'b1;
         else if (b_valid)                                   grant_b = 1'b1;
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_comb begin
      in_stage.data = grant_b ? b_data : a_data;
      in_stage.tag  = grant_b ? TAG_B : TAG_A;
   end

   sp_offset_lut u_lut (
      .operand (s1_q.data),
      .offset  (offset)
   );

   // Offset tables keep positive sums well below the sign bit, so no overflow.
   always_comb begin
      relu = s1_q.data[Q_W-1] ? '0 : s1_q.data;
      sum  = relu + offset;
   end

   // Next-state for both pipeline stages and the arbitration history.
   always_comb begin
      s1_n         = s1_q;
      s1_valid_n   = s1_valid;
      out_valid_n  = out_valid;
      out_data_n   = out_data;
      out_tag_n    = out_tag;
      last_grant_n = last_grant;

      if (s2_load) begin
         out_valid_n = s1_valid;
         if (s1_valid) begin
            out_data_n = sum;
            out_tag_n  = s1_q.tag;
         end
      end

      if (s1_can_load) begin
         s1_valid_n = grant_a | grant_b;
         if (grant_a | grant_b) begin
            s1_n         = in_stage;
            last_grant_n = in_stage.tag;
         end
      end

      busy_n = s1_valid_n | out_valid_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '{data: '0, tag: TAG_A};
         s1_valid   <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_tag    <= 1'b0;
         busy       <= 1'b0;
         last_grant <= TAG_B;
      end else begin
         s1_q       <= s1_n;
         s1_valid   <= s1_valid_n;
         out_valid  <= out_valid_n;
         out_data   <= out_data_n;
         out_tag    <= out_tag_n;
         busy       <= busy_n;
         last_grant <= last_grant_n;
      end
   end

endmodule

// File: tb/tb_softplus_arb.sv
// tb_softplus_arb: self-checking bench for softplus_arb. Expected results
// are pushed when an input transfer is seen and compared in order against
// observed output transfers.
module tb_softplus_arb;

   logic        clk, rst;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [15:0] a_data, b_data, out_data;
   logic        out_valid, out_ready, out_tag, busy;

   int          checks;
   int          passes;
   logic [16:0] exp_q [$];
   logic [16:0] obs_q [$];

   softplus_arb dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference softplus approximation.
   function automatic logic [15:0] model(input logic [15:0] x);
      logic [2:0]  i;
      logic [15:0] off;
      i = x[10:8];
      off = 16'h0000;
      if (!x[15]) begin
         case (i)
            3'd0: off = 16'h004D;
            3'd1: off = 16'h0037;
            3'd2: off = 16'h001F;
            3'd3: off = 16'h000F;
            3'd4: off = 16'h0007;
            default: off = 16'h0000;
         endcase
         return x + off;
      end
      case (i)
         3'd7: off = 16'h004D;
         3'd6: off = 16'h0037;
         3'd5: off = 16'h001F;
         3'd4: off = 16'h000F;
         3'd3: off = 16'h0007;
         default: off = 16'h0002;
      endcase
      return off;
   endfunction

   // Record transfers seen at the negative edge (inputs are stable here).
   task automatic sample();
      if (rst) begin
         exp_q.delete();
         obs_q.delete();
      end else begin
         if (a_valid && a_ready) exp_q.push_back({1'b0, model(a_data)});
         if (b_valid && b_ready) exp_q.push_back({1'b1, model(b_data)});
         if (out_valid && out_ready) obs_q.push_back({out_tag, out_data});
      end
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk); sample();
         @(posedge clk); #1;
         n++;
      end
      ok = !busy;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk); sample();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      a_data = 16'h0100; b_data = 16'h0200;
      @(negedge clk); sample();
      checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL reset_readies got %b want 00", {a_ready, b_ready}); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
      checks++; if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data); else passes++;
      checks++; if ({out_tag, busy} !== 2'b00) $display("FAIL reset_tag_busy got %b want 00", {out_tag, busy}); else passes++;
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
   endtask

   task automatic test_single();
      logic [16:0] e, o;
      bit ok;
      a_data = 16'h0000; a_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); sample();
      checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL single_grant got %b want 10", {a_ready, b_ready}); else passes++;
      @(posedge clk); #1; a_valid = 1'b0;
      @(negedge clk); sample();
      checks++; if ({out_valid, busy} !== 2'b01) $display("FAIL single_stage1 got %b want 01", {out_valid, busy}); else passes++;
      @(posedge clk); #1;
      @(negedge clk); sample();
      checks++; if ({out_valid, out_tag, out_data} !== {2'b10, 16'h004D}) $display("FAIL single_result got %b/%b/%h want 1/0/004d", out_valid, out_tag, out_data); else passes++;
      @(posedge clk); #1;
      @(negedge clk); sample();
      checks++; if ({out_valid, busy} !== 2'b00) $display("FAIL single_idle got %b want 00", {out_valid, busy}); else passes++;
      @(posedge clk); #1;
      drain(ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) $display("FAIL single_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) $display("FAIL single_sb got %h want %h", o, e); else passes++;
      end
   endtask

   task automatic test_values();
      logic        sel  [7];
      logic [15:0] din  [7];
      logic [15:0] dexp [7];
      logic [16:0] e, o;
      logic        rdy;
      bit          ok;
      sel  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      din  = '{16'h0180, 16'hFF00, 16'hF800, 16'h0500, 16'h0400, 16'h0280, 16'hFB80};
      dexp = '{16'h01B7, 16'h004D, 16'h0002, 16'h0500, 16'h0407, 16'h029F, 16'h0007};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (sel[i]) begin b_valid = 1'b1; b_data = din[i]; end
         else        begin a_valid = 1'b1; a_data = din[i]; end
         @(negedge clk); sample();
         rdy = sel[i] ? b_ready : a_ready;
         checks++; if (rdy !== 1'b1) $display("FAIL values_ready[%0d] got %b want 1", i, rdy); else passes++;
         @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
         @(negedge clk); sample();
         @(posedge clk); #1;
         @(negedge clk); sample();
         checks++; if ({out_valid, out_tag, out_data} !== {1'b1, sel[i], dexp[i]}) $display("FAIL values_result[%0d] got %b/%b/%h want 1/%b/%h", i, out_valid, out_tag, out_data, sel[i], dexp[i]); else passes++;
         @(posedge clk); #1;
      end
      drain(ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) $display("FAIL values_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) $display("FAIL values_sb got %h want %h", o, e); else passes++;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [16:0] e, o;
      logic [1:0]  want;
      logic        ra, rb;
      int          ia, ib;
      bit          ok;
      va = '{16'h0100, 16'h0180, 16'h7F00};
      vb = '{16'hF800, 16'hFF00, 16'h0300};
      apply_reset();
      ia = 0; ib = 0; out_ready = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1; a_data = va[0]; b_data = vb[0];
      for (int cyc = 0; cyc < 9; cyc++) begin
         @(negedge clk); sample();
         if (cyc < 6) begin
            want = (cyc % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if ({a_ready, b_ready} !== want) $display("FAIL b2b_grant[%0d] got %b want %b", cyc, {a_ready, b_ready}, want); else passes++;
         end
         if (cyc >= 2 && cyc <= 7) begin
            checks++; if ({out_valid, out_tag} !== {1'b1, 1'((cyc - 2) % 2)}) $display("FAIL b2b_out[%0d] got %b/%b want 1/%0d", cyc, out_valid, out_tag, (cyc - 2) % 2); else passes++;
         end
         if (cyc == 8) begin
            checks++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", out_valid); else passes++;
         end
         ra = a_ready; rb = b_ready;
         @(posedge clk); #1;
         if (ra) begin ia++; if (ia < 3) a_data = va[ia]; end
         if (rb) begin ib++; if (ib < 3) b_data = vb[ib]; end
         if (cyc == 5) begin a_valid = 1'b0; b_valid = 1'b0; end
      end
      drain(ok);
      checks++; if (!ok || obs_q.size() != 6 || exp_q.size() != 6) $display("FAIL b2b_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) $display("FAIL b2b_sb got %h want %h", o, e); else passes++;
      end
   endtask

   task automatic test_backpressure();
      logic [16:0] e, o;
      logic [1:0]  want;
      logic        ra, rb;
      int          nx;
      bit          ok;
      nx = 0;
      out_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
      a_data = 16'h0180; b_data = 16'hFF00;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk); sample();
         want = (cyc == 0) ? 2'b10 : (cyc == 1) ? 2'b01 : 2'b00;
         checks++; if ({a_ready, b_ready} !== want) $display("FAIL bp_ready[%0d] got %b want %b", cyc, {a_ready, b_ready}, want); else passes++;
         if (cyc >= 2) begin
            checks++; if ({out_valid, out_tag, out_data} !== {2'b10, 16'h01B7}) $display("FAIL bp_hold[%0d] got %b/%b/%h want 1/0/01b7", cyc, out_valid, out_tag, out_data); else passes++;
         end
         ra = a_ready; rb = b_ready;
         @(posedge clk); #1;
         if (ra) begin nx++; a_data = 16'h0400; end
         if (rb) begin nx++; b_data = 16'h0500; end
      end
      checks++; if (nx != 2) $display("FAIL bp_accepted got %0d want 2", nx); else passes++;
      out_ready = 1'b1;
      @(negedge clk); sample();
      checks++; if ({a_ready, b_ready, out_valid} !== 3'b101) $display("FAIL bp_resume got %b want 101", {a_ready, b_ready, out_valid}); else passes++;
      @(posedge clk); #1; a_valid = 1'b0;
      for (int n = 0; n < 5 && b_valid; n++) begin
         @(negedge clk); sample();
         rb = b_ready;
         @(posedge clk); #1;
         if (rb) b_valid = 1'b0;
      end
      checks++; if (b_valid !== 1'b0) $display("FAIL bp_b_timeout got %b want 0", b_valid); else passes++;
      b_valid = 1'b0;
      drain(ok);
      checks++; if (!ok || obs_q.size() != 4 || exp_q.size() != 4) $display("FAIL bp_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) $display("FAIL bp_sb got %h want %h", o, e); else passes++;
      end
   endtask

   task automatic test_reset_mid();
      logic [16:0] e, o;
      logic        ra, rb;
      bit          ok;
      out_ready = 1'b0; a_valid = 1'b1; a_data = 16'h0700; b_data = 16'h0080;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk); sample();
         ra = a_ready;
         @(posedge clk); #1;
         if (ra) a_data = a_data + 16'h0100;
      end
      b_valid = 1'b1;
      @(negedge clk); sample();
      checks++; if ({out_valid, busy, a_ready, b_ready} !== 4'b1100) $display("FAIL rmid_full got %b want 1100", {out_valid, busy, a_ready, b_ready}); else passes++;
      @(posedge clk); #1;
      rst = 1'b1; #1;
      checks++; if ({out_valid, busy, a_ready, b_ready} !== 4'b0000) $display("FAIL rmid_flush got %b want 0000", {out_valid, busy, a_ready, b_ready}); else passes++;
      @(negedge clk); sample();
      @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
      @(negedge clk); sample();
      checks++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL rmid_tie got %b want 10", {a_ready, b_ready}); else passes++;
      @(posedge clk); #1; a_valid = 1'b0;
      for (int n = 0; n < 5 && b_valid; n++) begin
         @(negedge clk); sample();
         rb = b_ready;
         @(posedge clk); #1;
         if (rb) b_valid = 1'b0;
      end
      checks++; if (b_valid !== 1'b0) $display("FAIL rmid_b_timeout got %b want 0", b_valid); else passes++;
      b_valid = 1'b0;
      drain(ok);
      checks++; if (!ok || obs_q.size() != 2 || exp_q.size() != 2) $display("FAIL rmid_sb_count got %0d want %0d", obs_q.size(), exp_q.size()); else passes++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         checks++; if (o !== e) $display("FAIL rmid_sb got %h want %h", o, e); else passes++;
      end
   endtask

   initial begin
      checks = 0; passes = 0;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
      a_data = 16'h0000; b_data = 16'h0000;
      test_reset();
      test_single();
      test_values();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
